dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with the ports listed below.
REQ-002 CLK  in  1  system clock; all state updates on rising edge.
REQ-003 RST_N  in  1  asynchronous active-low reset.
REQ-004 Pn_REQ  in  1  request from port n (n = 0 CPU, n = 1 loader/debug); held until granted.
REQ-005 Pn_WE  in  1  1 = store, 0 = load.
REQ-006 Pn_A  in  32  byte address; bits [1:0] ignored.
REQ-007 Pn_WD  in  32  store data, byte lanes aligned to word.
REQ-008 Pn_BE  in  4  store byte enables; BE[k] selects WD[8k+7:8k]; ignored for loads.
REQ-009 Pn_GNT  out  1  one-cycle pulse; request accepted this cycle.
REQ-010 Pn_RVALID  out  1  one-cycle pulse; transaction complete.
REQ-011 Pn_RDATA  out  32  word read (loads) or pre-store word (stores); valid with RVALID.
REQ-012 MEM_WE  out  1  write strobe to single-port word memory (combinational read, write on posedge).
REQ-013 MEM_A  out  32  word-aligned address {A[31:2], 2'b00}.
REQ-014 MEM_WD  out  32  write data.
REQ-015 MEM_RD  in  32  combinational read data for MEM_A.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS and MERGE_WR; exactly one transaction SHALL be in flight.
REQ-017 IDLE: if any REQ, arbiter SHALL pick a winner, pulse its GNT combinationally in that cycle, latch WE/A/WD/BE/port-id and go to ACCESS; no REQ -> stay IDLE, GNT = 0.
REQ-018 ACCESS: MEM_A SHALL be the latched word address; MEM_WE = 1 only for a store with BE = 4'b1111 (MEM_WD = latched WD); MEM_RD SHALL be captured into a read register.
REQ-019 ACCESS, load or full-word store: next state IDLE; partial store (BE not 0000/1111): next state MERGE_WR.
REQ-020 MERGE_WR: MEM_WE = 1, same MEM_A, MEM_WD byte k = WD byte k if BE[k] else captured byte k; next state IDLE.
REQ-021 Store with BE = 4'b0000 SHALL not assert MEM_WE and SHALL complete as a load-length transaction.
REQ-022 RVALID of the owning port SHALL pulse, with RDATA = captured word, in the cycle after the last memory cycle (load 2 cycles, full store 2, partial store 3, from GNT).
REQ-023 A new GNT MAY occur in the same cycle as the previous RVALID (back-to-back, no bubble).
REQ-024 RDATA of the non-owning port SHALL hold its previous value; RVALID SHALL never assert on both ports in one cycle.
REQ-025 MEM_WE SHALL be 0 in IDLE; MEM_A/MEM_WD in IDLE are don't-care but SHALL be driven from latched registers (no X).
REQ-026 Default arbitration SHALL be fixed priority, P0 over P1.

Reset
REQ-027 On RST_N = 0: state IDLE, GNT = 0, RVALID = 0, RDATA = 0, MEM_WE = 0 immediately (combinational from state), latched fields = 0.
REQ-028 Reset asserted mid-transaction SHALL abort it: no further MEM_WE, no RVALID; the requester re-issues after reset.

Configuration
REQ-029 Macro DMEM_ARB_RR_EN defined: round-robin arbitration; on simultaneous requests, the port not granted last wins; last-granted pointer resets to P1 so P0 wins the first tie.
REQ-030 Macro DMEM_ARB_RR_EN undefined: fixed priority per REQ-026; no pointer register is instantiated.

Verification
REQ-031 P0 load A=0x10, MEM word[4]=0xDEADBEEF -> P0_GNT in cycle 0, P0_RVALID in cycle 2, P0_RDATA=0xDEADBEEF, MEM_WE never 1.
REQ-032 P1 store A=0x8, WD=0x000000AB, BE=0001, word[2]=0x11223344 -> MEM_WE in cycle 2 only, word[2]=0x112233AB, P1_RVALID cycle 3 with RDATA=0x11223344.
REQ-033 P0 and P1 both request continuously with loads -> fixed build: only P0 granted; DMEM_ARB_RR_EN build: grants alternate P0, P1, P0, P1 every 2 cycles.
REQ-034 Store with BE=0000 to A=0x0 holding 0x55AA55AA -> MEM_WE never 1, word unchanged, RVALID cycle 2 with RDATA=0x55AA55AA.
REQ-035 RST_N pulled low during MERGE_WR of a partial store -> MEM_WE drops in the same cycle, target word unchanged, no RVALID, state IDLE after release.
REQ-036 Store A=0x13 (A[1:0]=11), BE=1111, WD=0xCAFEF00D -> word[4] written 0xCAFEF00D; A[1:0] ignored.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-port arbiter in front of a single-port word memory (combinational read,
// write on posedge). Port 0 is the CPU, port 1 the loader/debug port. Exactly
// one transaction is in flight at a time:
//   load / full-word store : GNT -> ACCESS -> RVALID            (2 cycles)
//   partial store          : GNT -> ACCESS -> MERGE_WR -> RVALID (3 cycles)
// A store with BE = 4'b0000 behaves like a load and never writes.
// RDATA returns the loaded word, or the pre-store word for stores.
//
// Optional feature macro: DMEM_ARB_RR_EN
//   undefined : fixed priority, port 0 beats port 1.
//   defined   : round-robin; on a tie the port not granted last wins. The
//               last-granted pointer resets to port 1 so port 0 wins first.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   pN_req_i                   request, held until granted
//   pN_we_i                    1 = store, 0 = load
//   pN_a_i[31:0]               byte address (bits [1:0] ignored)
//   pN_wd_i[31:0]              store data
//   pN_be_i[3:0]               store byte enables
//   pN_gnt_o                   combinational one-cycle grant pulse
//   pN_rvalid_o                one-cycle completion pulse
//   pN_rdata_o[31:0]           read / pre-store word, valid with rvalid
//   mem_we_o                   memory write strobe
//   mem_a_o[31:0]              word-aligned memory address
//   mem_wd_o[31:0]             memory write data
//   mem_rd_i[31:0]             memory combinational read data
// -----------------------------------------------------------------------------
module dmem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req_i,
  input  logic        p0_we_i,
  input  logic [31:0] p0_a_i,
  input  logic [31:0] p0_wd_i,
  input  logic [3:0]  p0_be_i,
  output logic        p0_gnt_o,
  output logic        p0_rvalid_o,
  output logic [31:0] p0_rdata_o,
  input  logic        p1_req_i,
  input  logic        p1_we_i,
  input  logic [31:0] p1_a_i,
  input  logic [31:0] p1_wd_i,
  input  logic [3:0]  p1_be_i,
  output logic        p1_gnt_o,
  output logic        p1_rvalid_o,
  output logic [31:0] p1_rdata_o,
  output logic        mem_we_o,
  output logic [31:0] mem_a_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    MERGE_WR = 2'd2
  } state_e;

  state_e      state_q;
  logic        we_q;
  logic [29:0] waddr_q;
  logic [31:0] wd_q;
  logic [3:0]  be_q;
  logic        id_q;      // owning port of the transaction in flight
  logic [31:0] cap_q;     // word captured during ACCESS
  logic [1:0]  rvalid_q;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;

  logic        any_req;
  logic        win_id;
  logic        partial;
  logic        finish;
  logic [31:0] fin_data;
  logic [31:0] merged;

  // Byte-address low bits are deliberately ignored.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{p0_a_i[1:0], p1_a_i[1:0]};

  assign any_req = p0_req_i | p1_req_i;

`ifdef DMEM_ARB_RR_EN
  logic last_q;  // port granted most recently
  assign win_id = (p0_req_i & p1_req_i) ? ~last_q : ~p0_req_i;
`else
  assign win_id = ~p0_req_i;
`endif

  // Grants are masked by reset so nothing is accepted while rst_n is low.
  assign p0_gnt_o = rst_n && (state_q == IDLE) && any_req && !win_id;
  assign p1_gnt_o = rst_n && (state_q == IDLE) && any_req &&  win_id;

  // BE of 0000 or 1111 needs no read-modify-write.
  assign partial = we_q && (be_q != 4'b0000) && (be_q != 4'b1111);

  // Write strobe comes straight from state so an async reset kills it at once.
  assign mem_we_o = ((state_q == ACCESS) && we_q && (be_q == 4'b1111)) ||
                    (state_q == MERGE_WR);

  // NOTE: every always_comb output gets a default before any conditional
  // assignment; a path that leaves it unassigned would infer a latch.
  always_comb begin
    merged = cap_q;
    for (int k = 0; k < 4; k++) begin
      if (be_q[k]) merged[8*k +: 8] = wd_q[8*k +: 8];
    end
  end

  assign mem_a_o  = {waddr_q, 2'b00};
  assign mem_wd_o = (state_q == MERGE_WR) ? merged : wd_q;

  // Last memory cycle of the transaction; in ACCESS the capture register is
  // not loaded yet, so the word is taken straight from the memory.
  assign finish   = ((state_q == ACCESS) && !partial) || (state_q == MERGE_WR);
  assign fin_data = (state_q == MERGE_WR) ? cap_q : mem_rd_i;

  assign p0_rvalid_o = rvalid_q[0];
  assign p1_rvalid_o = rvalid_q[1];
  assign p0_rdata_o  = rdata0_q;
  assign p1_rdata_o  = rdata1_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wd_q     <= '0;
      be_q     <= '0;
      id_q     <= 1'b0;
      cap_q    <= '0;
      rvalid_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef DMEM_ARB_RR_EN
      last_q   <= 1'b1;
`endif
    end else begin
      rvalid_q <= '0;
      if (finish) begin
        rvalid_q[id_q] <= 1'b1;
        if (id_q) rdata1_q <= fin_data;
        else      rdata0_q <= fin_data;
      end
      case (state_q)
        IDLE: begin
          if (any_req) begin
            id_q    <= win_id;
            we_q    <= win_id ? p1_we_i       : p0_we_i;
            waddr_q <= win_id ? p1_a_i[31:2]  : p0_a_i[31:2];
            wd_q    <= win_id ? p1_wd_i       : p0_wd_i;
            be_q    <= win_id ? p1_be_i       : p0_be_i;
`ifdef DMEM_ARB_RR_EN
            last_q  <= win_id;
`endif
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          cap_q   <= mem_rd_i;
          state_q <= partial ? MERGE_WR : IDLE;
        end
        MERGE_WR: state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Self-checking bench for dmem_arbiter. A 64-word memory model sits on the
// memory port; a reference word array plus per-transaction latency/strobe
// expectations are derived from the transaction rules (2 cycles for loads and
// full or empty stores, 3 for partial stores, write only for non-empty BE).
// Honors DMEM_ARB_RR_EN for the arbitration expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req, we;
  logic [31:0] a   [2];
  logic [31:0] wd  [2];
  logic [3:0]  be  [2];
  logic [1:0]  gnt, rvalid;
  logic [31:0] rdata0, rdata1;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  dmem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .p0_req_i   (req[0]),
    .p0_we_i    (we[0]),
    .p0_a_i     (a[0]),
    .p0_wd_i    (wd[0]),
    .p0_be_i    (be[0]),
    .p0_gnt_o   (gnt[0]),
    .p0_rvalid_o(rvalid[0]),
    .p0_rdata_o (rdata0),
    .p1_req_i   (req[1]),
    .p1_we_i    (we[1]),
    .p1_a_i     (a[1]),
    .p1_wd_i    (wd[1]),
    .p1_be_i    (be[1]),
    .p1_gnt_o   (gnt[1]),
    .p1_rvalid_o(rvalid[1]),
    .p1_rdata_o (rdata1),
    .mem_we_o   (mem_we),
    .mem_a_o    (mem_a),
    .mem_wd_o   (mem_wd),
    .mem_rd_i   (mem_rd)
  );

  // Memory model: combinational read, write on posedge; bench preload port.
  logic [31:0] mem [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;
  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge clk) begin
    if (pl_en)       mem[pl_idx] <= pl_val;
    else if (mem_we) mem[mem_a[7:2]] <= mem_wd;
  end

  // Reference model state
  logic [31:0] ref_mem [64];
  int          model_last = 1;
  int          checks = 0;
  int          errors = 0;

  task automatic preload(input int idx, input logic [31:0] val);
    pl_en = 1'b1; pl_idx = 6'(idx); pl_val = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[idx] = val;
  endtask

  task automatic check_mem(input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s memory: %0d words differ from expected contents", nm, bad);
    end
  endtask

  // One isolated transaction on port p, checked end to end.
  task automatic run_txn(input int p, input logic w, input logic [31:0] addr,
                         input logic [31:0] d, input logic [3:0] b, input string nm);
    int idx, exp_lat, t, vt, we_mask, exp_mask;
    logic [31:0] old_w, new_w, got, other_before, other_after;
    bit done, bad_other;
    idx      = int'(addr[7:2]);
    old_w    = ref_mem[idx];
    new_w    = old_w;
    if (w) for (int k = 0; k < 4; k++) if (b[k]) new_w[8*k +: 8] = d[8*k +: 8];
    exp_lat  = (w && b != 4'b0000 && b != 4'b1111) ? 3 : 2;
    exp_mask = (w && b != 4'b0000) ? (1 << (exp_lat - 1)) : 0;
    other_before = (p == 1) ? rdata0 : rdata1;
    req[p] = 1'b1; we[p] = w; a[p] = addr; wd[p] = d; be[p] = b;
    t = -1; vt = -1; we_mask = 0; done = 0; bad_other = 0; got = '0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (t >= 0) t++;
      else if (gnt[p]) t = 0;
      if (gnt[1-p]) bad_other = 1;
      if (rvalid[1-p]) bad_other = 1;
      if (mem_we) we_mask |= (t >= 0 && t < 16) ? (1 << t) : (1 << 16);
      if (rvalid[p]) begin
        vt   = t;
        got  = (p == 1) ? rdata1 : rdata0;
        done = 1;
      end
      @(posedge clk); #1;
      if (t >= 0) req[p] = 1'b0;
    end
    req[p] = 1'b0;
    other_after = (p == 1) ? rdata0 : rdata1;

    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: no rvalid within 20 cycles (grant at %0d)", nm, t);
    end
    checks++;
    if (vt !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", nm, vt, exp_lat);
    end
    checks++;
    if (got !== old_w) begin
      errors++;
      $display("FAIL %s rdata: got %h expected %h", nm, got, old_w);
    end
    checks++;
    if (we_mask !== exp_mask) begin
      errors++;
      $display("FAIL %s mem_we cycles: got mask %h expected %h", nm, we_mask, exp_mask);
    end
    checks++;
    if (bad_other || other_after !== other_before) begin
      errors++;
      $display("FAIL %s other port: stray=%0d rdata %h expected %h", nm, bad_other,
               other_after, other_before);
    end
    ref_mem[idx] = new_w;
    model_last   = p;
    check_mem(nm);
  endtask

  task automatic test_reset();
    req = '0; we = '0;
    for (int i = 0; i < 2; i++) begin a[i] = '0; wd[i] = '0; be[i] = '0; end
    rst_n = 1'b0;
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    req[0] = 1'b1;
    #1;
    checks++;
    if (gnt !== 2'b00 || rvalid !== 2'b00 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset strobes: gnt=%b rvalid=%b mem_we=%b expected 00 00 0", gnt, rvalid, mem_we);
    end
    checks++;
    if (rdata0 !== 32'h0 || rdata1 !== 32'h0 || mem_a !== 32'h0 || mem_wd !== 32'h0) begin
      errors++;
      $display("FAIL reset values: rdata0=%h rdata1=%h mem_a=%h mem_wd=%h expected all 0",
               rdata0, rdata1, mem_a, mem_wd);
    end
    req[0] = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    model_last = 1;
  endtask

  task automatic test_directed();
    preload(4, 32'hDEADBEEF);
    run_txn(0, 1'b0, 32'h10, $urandom, 4'($urandom), "p0_load");
    preload(2, 32'h11223344);
    run_txn(1, 1'b1, 32'h8, 32'h000000AB, 4'b0001, "p1_partial_store");
    preload(0, 32'h55AA55AA);
    run_txn(0, 1'b1, 32'h0, $urandom, 4'b0000, "empty_be_store");
    run_txn(0, 1'b1, 32'h13, 32'hCAFEF00D, 4'b1111, "full_store_unaligned");
    run_txn(1, 1'b0, 32'h12, '0, '0, "p1_readback");
  endtask

  task automatic test_random();
    logic [7:0]  ad;
    logic [3:0]  bb;
    for (int n = 0; n < 30; n++) begin
      ad = 8'($urandom);
      bb = 4'($urandom);
      run_txn(int'($urandom_range(0, 1)), 1'($urandom), {24'h0, ad}, $urandom, bb, "random");
    end
  endtask

  // Both ports request loads continuously; grants every second cycle.
  task automatic test_back_to_back();
    int sched [6];
    int idx [2];
    logic [1:0] exp_g, exp_v;
    logic [31:0] exp_d, got_d;
    idx[0] = 5; idx[1] = 9;
`ifdef DMEM_ARB_RR_EN
    sched[0] = 1 - model_last;
    for (int i = 1; i < 6; i++) sched[i] = 1 - sched[i-1];
`else
    for (int i = 0; i < 6; i++) sched[i] = 0;
`endif
    for (int i = 0; i < 2; i++) begin
      we[i] = 1'b0; a[i] = 32'(idx[i] * 4); wd[i] = '0; be[i] = 4'hF;
    end
    req = 2'b11;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      exp_g = '0; exp_v = '0; exp_d = '0;
      if (c % 2 == 0 && c <= 10) exp_g[sched[c/2]] = 1'b1;
      if (c % 2 == 0 && c >= 2 && c <= 12) begin
        exp_v[sched[c/2-1]] = 1'b1;
        exp_d = ref_mem[idx[sched[c/2-1]]];
      end
      checks++;
      if (gnt !== exp_g || rvalid !== exp_v || mem_we !== 1'b0) begin
        errors++;
        $display("FAIL b2b cycle %0d: gnt=%b rvalid=%b mem_we=%b expected %b %b 0",
                 c, gnt, rvalid, mem_we, exp_g, exp_v);
      end
      if (exp_v != 2'b00) begin
        got_d = exp_v[1] ? rdata1 : rdata0;
        checks++;
        if (got_d !== exp_d) begin
          errors++;
          $display("FAIL b2b rdata cycle %0d: got %h expected %h", c, got_d, exp_d);
        end
      end
      @(posedge clk); #1;
      if (c == 10) req = 2'b00;
    end
    model_last = sched[5];
  endtask

  // Reset during MERGE_WR aborts the partial store.
  task automatic test_reset_abort();
    bit seen_v;
    preload(7, 32'hA5A5A5A5);
    we[1] = 1'b1; a[1] = 32'h1C; wd[1] = 32'h12345678; be[1] = 4'b0110;
    req[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 2'b10) begin
      errors++;
      $display("FAIL abort grant: gnt=%b expected 10", gnt);
    end
    @(posedge clk); #1; req[1] = 1'b0;   // ACCESS
    @(posedge clk); #1;                  // MERGE_WR
    checks++;
    if (mem_we !== 1'b1) begin
      errors++;
      $display("FAIL abort merge strobe: mem_we=%b expected 1", mem_we);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || rvalid !== 2'b00 || rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL abort in reset: mem_we=%b rvalid=%b rdata0=%h rdata1=%h expected 0 00 0 0",
               mem_we, rvalid, rdata0, rdata1);
    end
    seen_v = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rvalid != 2'b00 || mem_we) seen_v = 1;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rvalid != 2'b00 || mem_we) seen_v = 1;
    end
    checks++;
    if (seen_v) begin
      errors++;
      $display("FAIL abort after reset: stray rvalid or mem_we observed");
    end
    @(posedge clk); #1;
    model_last = 1;
    check_mem("abort");
    run_txn(1, 1'b0, 32'h1C, '0, '0, "after_abort_load");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_back_to_back();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
